// File: rtl/trdb_resync_counter_pkg.sv
// trdb_resync_counter_pkg: packet format, sync subformat, resync mode/state types and counter width
package trdb_resync_counter_pkg;
  localparam int RESYNC_CNT_W = 16;
  typedef enum logic [1:0] {F_OPT_EXT = 2'h0, F_DIFF_DELTA = 2'h1, F_ADDR_ONLY = 2'h2, F_SYNC = 2'h3} trdb_format_e;
  typedef enum logic [1:0] {SF_START = 2'h0, SF_TRAP = 2'h1, SF_CONTEXT = 2'h2, SF_SUPPORT = 2'h3} trdb_f_sync_subformat_e;
  typedef enum logic [0:0] {CYCLE_MODE = 1'b0, PACKET_MODE = 1'b1} trdb_resync_mode_e;
  typedef enum logic [1:0] {RS_IDLE, RS_COUNTING, RS_PENDING, RS_URGENT} trdb_resync_state_e;
endpackage

// File: rtl/trdb_resync_counter_if.sv
// trdb_resync_counter_if: control/packet inputs (enable, mode, threshold, flush, pkt_*) and resync/urgent/count outputs
interface trdb_resync_counter_if
  import trdb_resync_counter_pkg::*;
#(
  parameter int CNT_W = RESYNC_CNT_W
) ();
  logic             enable_i;
  logic             mode_i;
  logic [CNT_W-1:0] threshold_i;
  logic             flush_i;
  logic             pkt_valid_i;
  logic [1:0]       pkt_format_i;
  logic [1:0]       pkt_subformat_i;
  logic             resync_o;
  logic             urgent_o;
  logic [CNT_W-1:0] count_o;
  modport master (
    output enable_i, mode_i, threshold_i, flush_i, pkt_valid_i, pkt_format_i, pkt_subformat_i,
    input  resync_o, urgent_o, count_o
  );
  modport slave (
    input  enable_i, mode_i, threshold_i, flush_i, pkt_valid_i, pkt_format_i, pkt_subformat_i,
    output resync_o, urgent_o, count_o
  );
endinterface

// File: rtl/trdb_resync_counter.sv
// trdb_resync_counter: resync timer (clk_i, async rst_i, bus.slave) raising resync_o after threshold events and urgent_o after a second period
module trdb_resync_counter
  import trdb_resync_counter_pkg::*;
#(
  parameter int CNT_W  = RESYNC_CNT_W,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  trdb_resync_counter_if.slave bus
);
  trdb_resync_state_e state_q;
  trdb_resync_mode_e  mode_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W:0]     cnt_inc;
  logic [CNT_W-1:0]   cnt_sat;
  logic               resync_q, urgent_q, sync_evt, inc_evt, hit;
  assign sync_evt = bus.pkt_valid_i && bus.pkt_format_i == F_SYNC &&
                    (bus.pkt_subformat_i == SF_START || bus.pkt_subformat_i == SF_TRAP);
  assign inc_evt  = bus.mode_i == PACKET_MODE ? bus.pkt_valid_i && !sync_evt : 1'b1;
  assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign hit      = bus.threshold_i != '0 && cnt_inc >= {1'b0, bus.threshold_i};
  assign cnt_sat  = SAT_EN && (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RS_IDLE;
      mode_q   <= CYCLE_MODE;
      cnt_q    <= '0;
      resync_q <= 1'b0;
      urgent_q <= 1'b0;
    end else begin
      mode_q <= trdb_resync_mode_e'(bus.mode_i);
      if (!bus.enable_i) begin
        state_q  <= RS_IDLE;
        cnt_q    <= '0;
        resync_q <= 1'b0;
        urgent_q <= 1'b0;
      end else if (state_q == RS_IDLE || bus.flush_i || sync_evt) begin
        state_q  <= RS_COUNTING;
        cnt_q    <= '0;
        resync_q <= 1'b0;
        urgent_q <= 1'b0;
      end else if (bus.mode_i != mode_q) begin
        cnt_q <= '0;
      end else if (inc_evt) begin
        if (state_q != RS_URGENT && hit) begin
          state_q  <= state_q == RS_COUNTING ? RS_PENDING : RS_URGENT;
          cnt_q    <= '0;
          resync_q <= 1'b1;
          urgent_q <= state_q == RS_PENDING;
        end else begin
          cnt_q <= cnt_sat;
        end
      end
    end
  end
  assign bus.resync_o = resync_q;
  assign bus.urgent_o = urgent_q;
  assign bus.count_o  = cnt_q;
endmodule
